// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion used by both pointer handlers.
package fifo_pkg;

   localparam int PTR_WIDTH_DEF = 4;

   // Conversions operate on a wide vector; callers zero-extend narrower
   // pointers and cast the result back, which is exact because leading zeros
   // are preserved by both transforms.
   localparam int GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      logic [GRAY_MAX_W-1:0] gray;
      gray[GRAY_MAX_W-1] = bin[GRAY_MAX_W-1];
      for (int i = 0; i < GRAY_MAX_W-1; i++) begin
         gray[i] = bin[i+1] ^ bin[i];
      end
      return gray;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage reset-to-zero synchronizer for a Gray-coded pointer.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync1;

   // First flop may go metastable; second flop gives it a cycle to resolve.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= '0;
         q     <= '0;
      end else begin
         sync1 <= d;
         q     <= sync1;
      end
   end

endmodule

// File: rtl/wr_ptr_handler.sv
// Write-side pointer stage of the async FIFO: owns the write pointers,
// synchronizes the read pointer and produces pessimistic full/level status.
//
// Handshake: wr_req is the producer's request, wr_en is the acceptance. A
// write happens exactly in a cycle where wr_en is high at the rising edge of
// clk. A request while full is dropped (not queued) and sets overflow.
module wr_ptr_handler
   import fifo_pkg::*;
#(
   parameter int PTR_WIDTH    = PTR_WIDTH_DEF,
   parameter int AFULL_THRESH = 12
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [PTR_WIDTH:0]   rd_ptr_gray,
   input  logic                 wr_req,
   input  logic                 clr_overflow,
   output logic                 wr_en,
   output logic [PTR_WIDTH-1:0] wr_addr,
   output logic                 full,
   output logic                 almost_full,
   output logic                 overflow,
   output logic [PTR_WIDTH:0]   level,
   output logic [PTR_WIDTH:0]   bin_wr_ptr,
   output logic [PTR_WIDTH:0]   gray_wr_ptr
);

   localparam int PW = PTR_WIDTH + 1;
   localparam logic [PTR_WIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

   logic [PTR_WIDTH:0] rd_sync2;
   logic [PTR_WIDTH:0] bin_rd_sync;
   logic [PTR_WIDTH:0] bin_wr_next;
   logic [PTR_WIDTH:0] gray_wr_next;
   logic [PTR_WIDTH:0] full_cmp;
   logic [PTR_WIDTH:0] level_next;
   logic               full_next;
   logic               almost_full_next;

   sync_2ff #(
      .WIDTH (PW)
   ) u_rd_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (rd_ptr_gray),
      .q    (rd_sync2)
   );

   // rstn term forces wr_en low during reset without waiting for a clock.
   assign wr_en   = rstn & wr_req & ~full;
   assign wr_addr = bin_wr_ptr[PTR_WIDTH-1:0];

   assign bin_wr_next  = bin_wr_ptr + PW'(wr_en);
   assign gray_wr_next = PW'(bin2gray(GRAY_MAX_W'(bin_wr_next)));
   assign bin_rd_sync  = PW'(gray2bin(GRAY_MAX_W'(rd_sync2)));

   // Full when write pointer is exactly one lap ahead: in Gray code that is
   // the top two bits inverted and the rest equal.
   assign full_cmp         = {~rd_sync2[PTR_WIDTH:PTR_WIDTH-1], rd_sync2[PTR_WIDTH-2:0]};
   assign full_next        = (gray_wr_next == full_cmp);
   assign level_next       = bin_wr_next - bin_rd_sync;
   assign almost_full_next = (level_next >= AFULL_LVL);

   // Pointer and status registers all advance from the same _next values so
   // they stay mutually consistent; stale read pointer only overstates level.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bin_wr_ptr  <= '0;
         gray_wr_ptr <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         level       <= '0;
      end else begin
         bin_wr_ptr  <= bin_wr_next;
         gray_wr_ptr <= gray_wr_next;
         full        <= full_next;
         almost_full <= almost_full_next;
         level       <= level_next;
      end
   end

   // Sticky overflow: a dropped write in the same cycle beats a clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow <= 1'b0;
      end else if (wr_req && full) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wr_ptr_handler.sv
// Self-checking bench for wr_ptr_handler (PTR_WIDTH=4, AFULL_THRESH=12).
module tb_wr_ptr_handler;

   localparam int PTR_WIDTH = 4;
   localparam int AFULL_THRESH = 12;

   logic                 clk;
   logic                 rstn;
   logic [PTR_WIDTH:0]   rd_ptr_gray;
   logic                 wr_req;
   logic                 clr_overflow;
   logic                 wr_en;
   logic [PTR_WIDTH-1:0] wr_addr;
   logic                 full;
   logic                 almost_full;
   logic                 overflow;
   logic [PTR_WIDTH:0]   level;
   logic [PTR_WIDTH:0]   bin_wr_ptr;
   logic [PTR_WIDTH:0]   gray_wr_ptr;

   int checks;
   int failures;

   // scoreboard of expected RAM write addresses
   logic [PTR_WIDTH-1:0] exp_q[$];

   // bench-side reference state (binary arithmetic)
   logic [PTR_WIDTH:0] m_wr;
   logic [PTR_WIDTH:0] m_s1;
   logic [PTR_WIDTH:0] m_s2;
   logic               m_full;

   wr_ptr_handler #(
      .PTR_WIDTH    (PTR_WIDTH),
      .AFULL_THRESH (AFULL_THRESH)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .rd_ptr_gray  (rd_ptr_gray),
      .wr_req       (wr_req),
      .clr_overflow (clr_overflow),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .full         (full),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .level        (level),
      .bin_wr_ptr   (bin_wr_ptr),
      .gray_wr_ptr  (gray_wr_ptr)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PTR_WIDTH:0] tb_b2g(input logic [PTR_WIDTH:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PTR_WIDTH:0] tb_g2b(input logic [PTR_WIDTH:0] g);
      logic [PTR_WIDTH:0] b;
      b = '0;
      for (int i = PTR_WIDTH; i >= 0; i--) begin
         b[i] = g[i] ^ ((i == PTR_WIDTH) ? 1'b0 : b[i+1]);
      end
      return b;
   endfunction

   // write monitor: every accepted write is popped against the scoreboard
   always @(negedge clk) begin
      if (rstn && wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_write got_addr=%0d exp=none", wr_addr);
         end else begin
            logic [PTR_WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (wr_addr !== e) begin
               failures++;
               $display("FAIL sb_wr_addr got=%0d exp=%0d", wr_addr, e);
            end
         end
      end
   end

   task automatic model_reset();
      m_wr   = '0;
      m_s1   = '0;
      m_s2   = '0;
      m_full = 1'b0;
   endtask

   // one clock cycle: drive inputs, update model, return at posedge+2
   task automatic cycle(input logic req, input logic clr);
      logic               accept;
      logic [PTR_WIDTH:0] nxt;
      logic [PTR_WIDTH:0] lvl;
      wr_req       = req;
      clr_overflow = clr;
      accept = req && !m_full;
      if (accept) exp_q.push_back(m_wr[PTR_WIDTH-1:0]);
      nxt    = m_wr + {{PTR_WIDTH{1'b0}}, accept};
      lvl    = nxt - tb_g2b(m_s2);
      m_full = (lvl == 5'd16);
      m_s2   = m_s1;
      m_s1   = rd_ptr_gray;
      m_wr   = nxt;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rstn         = 1'b0;
      wr_req       = 1'b0;
      clr_overflow = 1'b0;
      rd_ptr_gray  = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn         = 1'b0;
      wr_req       = 1'b1;
      clr_overflow = 1'b0;
      rd_ptr_gray  = '0;
      model_reset();
      #23;
      checks++;
      if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
      checks++;
      if ({full, almost_full, overflow, level, bin_wr_ptr, gray_wr_ptr, wr_addr} !== '0) begin
         failures++;
         $display("FAIL rst_outputs got full=%b af=%b ovf=%b lvl=%0d bin=%0d gray=%0d addr=%0d exp all 0",
                  full, almost_full, overflow, level, bin_wr_ptr, gray_wr_ptr, wr_addr);
      end
      @(posedge clk);
      #2;
      rstn = 1'b1;
      #1;
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 4'd0) begin
         failures++;
         $display("FAIL rst_first_write got wr_en=%b addr=%0d exp wr_en=1 addr=0", wr_en, wr_addr);
      end
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      checks++;
      if (bin_wr_ptr !== 5'd1) begin failures++; $display("FAIL rst_ptr_after_write got=%0d exp=1", bin_wr_ptr); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 1'b0);
         if (i == 11) begin
            checks++;
            if (almost_full !== 1'b0 || level !== 5'd11) begin
               failures++;
               $display("FAIL fill_11 got af=%b lvl=%0d exp af=0 lvl=11", almost_full, level);
            end
         end
         if (i == 12) begin
            checks++;
            if (almost_full !== 1'b1 || level !== 5'd12) begin
               failures++;
               $display("FAIL fill_12 got af=%b lvl=%0d exp af=1 lvl=12", almost_full, level);
            end
         end
         if (i == 15) begin
            checks++;
            if (full !== 1'b0) begin failures++; $display("FAIL fill_15_full got=%b exp=0", full); end
         end
      end
      checks++;
      if (full !== 1'b1 || bin_wr_ptr !== 5'b10000 || gray_wr_ptr !== 5'b11000) begin
         failures++;
         $display("FAIL fill_16 got full=%b bin=%b gray=%b exp full=1 bin=10000 gray=11000",
                  full, bin_wr_ptr, gray_wr_ptr);
      end
      wr_req = 1'b1;
      #1;
      checks++;
      if (wr_en !== 1'b0) begin failures++; $display("FAIL fill_17_wr_en got=%b exp=0", wr_en); end
      cycle(1'b1, 1'b0);
      checks++;
      if (bin_wr_ptr !== 5'b10000 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL fill_17_ovf got bin=%b ovf=%b exp bin=10000 ovf=1", bin_wr_ptr, overflow);
      end
   endtask

   task automatic test_overflow_clear();
      cycle(1'b0, 1'b1);
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
      cycle(1'b1, 1'b0);
      checks++;
      if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_reset got=%b exp=1", overflow); end
      cycle(1'b1, 1'b1);
      checks++;
      if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
      wr_req       = 1'b0;
      clr_overflow = 1'b0;
   endtask

   task automatic test_drain();
      rd_ptr_gray = 5'b00110;
      for (int e = 1; e <= 2; e++) begin
         cycle(1'b0, 1'b0);
         checks++;
         if (full !== 1'b1 || level !== 5'd16) begin
            failures++;
            $display("FAIL drain_early_edge%0d got full=%b lvl=%0d exp full=1 lvl=16", e, full, level);
         end
      end
      cycle(1'b0, 1'b0);
      checks++;
      if (full !== 1'b0 || level !== 5'd12 || almost_full !== 1'b1) begin
         failures++;
         $display("FAIL drain_edge3 got full=%b lvl=%0d af=%b exp full=0 lvl=12 af=1", full, level, almost_full);
      end
   endtask

   task automatic test_wrap();
      logic [PTR_WIDTH:0] p;
      do_reset();
      for (int i = 0; i < 31; i++) begin
         p = 5'(i);
         rd_ptr_gray = tb_b2g(p);
         cycle(1'b1, 1'b0);
      end
      checks++;
      if (bin_wr_ptr !== 5'd31 || gray_wr_ptr !== 5'b10000 || full !== 1'b0) begin
         failures++;
         $display("FAIL wrap_at31 got bin=%0d gray=%b full=%b exp bin=31 gray=10000 full=0",
                  bin_wr_ptr, gray_wr_ptr, full);
      end
      rd_ptr_gray = 5'b10000;
      cycle(1'b1, 1'b0);
      checks++;
      if (bin_wr_ptr !== 5'd0 || gray_wr_ptr !== 5'b00000) begin
         failures++;
         $display("FAIL wrap_to0 got bin=%0d gray=%b exp bin=0 gray=00000", bin_wr_ptr, gray_wr_ptr);
      end
      rd_ptr_gray = 5'b00000;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      checks++;
      if (level !== 5'd0 || full !== 1'b0) begin
         failures++;
         $display("FAIL wrap_settle got lvl=%0d full=%b exp lvl=0 full=0", level, full);
      end
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 1'b0);
         if (i == 15) begin
            checks++;
            if (full !== 1'b0) begin failures++; $display("FAIL wrap_fill15 got full=%b exp=0", full); end
         end
      end
      checks++;
      if (full !== 1'b1 || level !== 5'd16) begin
         failures++;
         $display("FAIL wrap_fill16 got full=%b lvl=%0d exp full=1 lvl=16", full, level);
      end
      wr_req = 1'b0;
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      n = $urandom_range(0, 1);
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
      checks++;
      if (level !== 5'd7 || bin_wr_ptr !== 5'd7) begin
         failures++;
         $display("FAIL areset_pre got lvl=%0d bin=%0d exp lvl=7 bin=7", level, bin_wr_ptr);
      end
      wr_req = 1'b1;
      #1;
      rstn = 1'b0;
      #1;
      checks++;
      if (wr_en !== 1'b0 || {full, almost_full, overflow, level, bin_wr_ptr, gray_wr_ptr, wr_addr} !== '0) begin
         failures++;
         $display("FAIL areset_async got wr_en=%b lvl=%0d bin=%0d gray=%0d addr=%0d exp all 0",
                  wr_en, level, bin_wr_ptr, gray_wr_ptr, wr_addr);
      end
      model_reset();
      @(posedge clk);
      #2;
      rstn = 1'b1;
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      checks++;
      if (bin_wr_ptr !== 5'd1) begin failures++; $display("FAIL areset_after got bin=%0d exp=1", bin_wr_ptr); end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rstn         = 1'b0;
      wr_req       = 1'b0;
      clr_overflow = 1'b0;
      rd_ptr_gray  = '0;
      model_reset();
      test_reset();
      test_fill();
      test_overflow_clear();
      test_drain();
      test_wrap();
      test_async_reset();
      cycle(1'b0, 1'b0);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // watchdog against a stalled run
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wr_ptr_handler.md
# wr_ptr_handler

Write-domain pointer stage of the asynchronous FIFO, the counterpart of the read-side pointer handler. It owns the binary and Gray write pointers and brings the read-domain Gray pointer across with a 2-FF synchronizer. From these it derives registered full, almost_full, level and sticky overflow status, and gates write requests into the dual-port RAM write enable and address.

## Interface
- PTR_WIDTH, 4, RAM address bits; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits; legal range PTR_WIDTH >= 2
- AFULL_THRESH, 12, level at or above which almost_full asserts; legal range 1..2**PTR_WIDTH

Ports:
- clk  in  1  write-domain clock
- rstn  in  1  asynchronous active-low reset
- rd_ptr_gray  in  PTR_WIDTH+1  Gray read pointer from the read domain (asynchronous to clk)
- wr_req  in  1  producer write request
- clr_overflow  in  1  clears the sticky overflow flag
- wr_en  out  1  RAM write enable
- wr_addr  out  PTR_WIDTH  RAM write address
- full  out  1  FIFO full, registered
- almost_full  out  1  level >= AFULL_THRESH, registered
- overflow  out  1  sticky: write requested while full
- level  out  PTR_WIDTH+1  write-side occupancy estimate, registered
- bin_wr_ptr  out  PTR_WIDTH+1  binary write pointer
- gray_wr_ptr  out  PTR_WIDTH+1  Gray write pointer to the read-domain synchronizer, registered

## Operation
- Write acceptance:
  - wr_en = wr_req & ~full (combinational).
  - wr_addr = bin_wr_ptr[PTR_WIDTH-1:0].
- Pointers:
  - On wr_en, bin_wr_next = bin_wr_ptr + 1, modulo 2**(PTR_WIDTH+1); otherwise bin_wr_next = bin_wr_ptr.
  - gray_wr_ptr is registered from bin2gray(bin_wr_next), never decoded combinationally from bin_wr_ptr, so the read domain never sees glitches.
- Synchronizer: rd_ptr_gray passes through two flops (rd_sync1, then rd_sync2). bin_rd_sync = gray2bin(rd_sync2), computed combinationally.
- full_next: (bin2gray(bin_wr_next) == {~rd_sync2[PTR_WIDTH:PTR_WIDTH-1], rd_sync2[PTR_WIDTH-2:0]}).
- level_next: bin_wr_next - bin_rd_sync, truncated to PTR_WIDTH+1 bits.
- almost_full_next: (level_next >= AFULL_THRESH).
- full, level and almost_full are all registered from their _next values.
- Flags are pessimistic by design:
  - full may stay asserted after a read, never deasserts early.
  - level may overstate occupancy, never understates it.
- overflow:
  - Set on any cycle with wr_req & full.
  - Cleared by clr_overflow when no set condition is present; set wins if both occur in the same cycle.
- Reset values: every pointer, every synchronizer flop, full, almost_full, level and overflow are 0. wr_en is 0 while rstn is low, through the rstn term on wr_en. wr_addr is 0.

## Timing
- Write to pointer: an accepted write at edge N updates bin_wr_ptr, gray_wr_ptr, full, level and almost_full at edge N, so they are valid in cycle N+1.
- Back-to-back: one write per cycle is sustainable. Full asserts in the same edge as the write that fills the FIFO, so no extra write slips through.
- Read pointer to flags: a change on rd_ptr_gray that is stable before edge M appears in rd_sync2 after edge M+1. full, level and almost_full reflect it after edge M+2 (3-edge worst case).
- Simultaneous write and read-pointer update: both take effect in the same _next computation. The result is consistent and never indicates more free space than actually exists.
- Wrap-around: the pointer goes from 2**(PTR_WIDTH+1)-1 to 0. Gray changes exactly one bit. full and level remain correct across the wrap through modular arithmetic.
- Reset mid-operation: asynchronous clear takes effect immediately. wr_en drops without waiting for a clock edge. The first write after rstn deasserts goes to address 0.

## Structure
- Package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterized through width-generic loops and shared with the read side;
  - localparam default PTR_WIDTH.
- One sub-module, sync_2ff: WIDTH parameter, clk and rstn ports, two-stage reset-to-0 flop chain. It is instantiated for rd_ptr_gray and is reused by the read side for the write pointer.

## Test plan
Defaults for all scenarios: PTR_WIDTH=4, AFULL_THRESH=12.
1. Reset: hold rstn low with wr_req=1 -> wr_en=0, all outputs 0. Release -> first write has wr_addr=0.
2. Fill: rd_ptr_gray=0, issue 16 consecutive wr_req.
   - After the 12th write: almost_full=1, level=12.
   - After the 16th write: full=1, bin_wr_ptr=5'b10000, gray_wr_ptr=5'b11000.
   - 17th wr_req: wr_en=0, pointer unchanged, overflow=1.
3. Overflow clear: pulse clr_overflow while full and wr_req=0 -> overflow=0 next cycle. Same cycle with wr_req=1 -> overflow stays 1.
4. Drain visibility: from full, set rd_ptr_gray=5'b00110 (binary 4) -> full=0, level=12, almost_full=1 exactly 3 edges later, not earlier.
5. Wrap:
   - Advance both pointers to 31 by 31 writes against a tracking read pointer. Next write -> bin_wr_ptr=0, gray_wr_ptr goes from 5'b10000 to 5'b00000.
   - Then 16 writes with rd_ptr_gray=5'b00000 after the wrap -> full=1.
6. Async reset mid-fill: with level=7, assert rstn between edges -> all outputs 0 immediately, without a clock edge.
